// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between decode, the GRF writeback path
// and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int ADDR_W = 5
);
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_rs;
  logic              iss_rs_use;
  logic [ADDR_W-1:0] iss_rt;
  logic              iss_rt_use;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_rd;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic              flush;
  logic              busy_rs;
  logic              busy_rt;
  logic              pending_any;
  logic              wb_err;

  modport master (
    output iss_valid, iss_rs, iss_rs_use,
    output iss_rt, iss_rt_use, iss_we, iss_rd,
    output wb_we, wb_addr, flush,
    input  iss_ready, busy_rs, busy_rt,
    input  pending_any, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rs_use,
    input  iss_rt, iss_rt_use, iss_we, iss_rd,
    input  wb_we, wb_addr, flush,
    output iss_ready, busy_rs, busy_rt,
    output pending_any, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters that stall issue on RAW hazards.
// Define SCOREBOARD_WB_BYPASS_EN to release a register in its writeback cycle.
module reg_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             wb_err_q;
  logic             wb_err_d;

  logic [CNT_W-1:0] rs_c;
  logic [CNT_W-1:0] rt_c;
  logic [CNT_W-1:0] rd_c;
  logic [CNT_W-1:0] wb_c;
  logic             byp_rs;
  logic             byp_rt;
  logic             busy_rs;
  logic             busy_rt;
  logic             sat;
  logic             ready;
  logic             accept;
  logic             pend;

  // Hazard detection and issue handshake
  always_comb begin
    rs_c   = cnt_q[sb.iss_rs];
    rt_c   = cnt_q[sb.iss_rt];
    rd_c   = cnt_q[sb.iss_rd];
    wb_c   = cnt_q[sb.wb_addr];
    byp_rs = 1'b0;
    byp_rt = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    byp_rs = sb.wb_we && (sb.wb_addr == sb.iss_rs)
             && (rs_c == CONE);
    byp_rt = sb.wb_we && (sb.wb_addr == sb.iss_rt)
             && (rt_c == CONE);
`endif
    busy_rs = sb.iss_rs_use && (sb.iss_rs != '0)
              && (rs_c != '0) && !byp_rs;
    busy_rt = sb.iss_rt_use && (sb.iss_rt != '0)
              && (rt_c != '0) && !byp_rt;
    sat     = sb.iss_we && (sb.iss_rd != '0)
              && (rd_c == CMAX);
    ready   = !sb.flush && !busy_rs && !busy_rt && !sat;
    accept  = sb.iss_valid && ready;
  end

  // Reduction of all counters for pending_any
  always_comb begin
    pend = 1'b0;
    for (int r = 0; r < NREG; r++)
      pend = pend | (cnt_q[r] != '0);
  end

  // Next counter values and sticky writeback error
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NREG; r++)
      cnt_d[r] = cnt_q[r];
    for (int r = 1; r < NREG; r++) begin
      inc = accept && sb.iss_we
            && (sb.iss_rd == ADDR_W'(r));
      dec = sb.wb_we && (sb.wb_addr == ADDR_W'(r))
            && (cnt_q[r] != '0);
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CONE;
    end
    cnt_d[0] = '0;
    if (sb.flush)
      for (int r = 0; r < NREG; r++)
        cnt_d[r] = '0;
    wb_err_d = wb_err_q
               | (!sb.flush && sb.wb_we
                  && (sb.wb_addr != '0) && (wb_c == '0));
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      wb_err_q <= wb_err_d;
    end
  end

  assign sb.iss_ready   = ready;
  assign sb.busy_rs     = busy_rs;
  assign sb.busy_rt     = busy_rt;
  assign sb.pending_any = pend;
  assign sb.wb_err      = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table,
// hand-written flush/reset sequences and randomized model comparison.
module tb_reg_scoreboard;
  localparam int CMAXI = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic       rs_use;
    logic [4:0] rt;
    logic       rt_use;
    logic       we;
    logic [4:0] rd;
    logic       wb_we;
    logic [4:0] wb_addr;
    logic       flush;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] e;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   mc [32];
  bit   merr;

  reg_scoreboard_if #(.ADDR_W(5)) sb ();

  reg_scoreboard #(.CNT_W(2), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input bit v, input int rs, input bit rsu,
                             input int rt, input bit rtu, input bit we,
                             input int rd, input bit wbwe, input int wba,
                             input bit fl);
    in_t x;
    x.valid = v;
    x.rs = 5'(rs);
    x.rs_use = rsu;
    x.rt = 5'(rt);
    x.rt_use = rtu;
    x.we = we;
    x.rd = 5'(rd);
    x.wb_we = wbwe;
    x.wb_addr = 5'(wba);
    x.flush = fl;
    return x;
  endfunction

  function automatic vec_t mv(input in_t i, input logic [4:0] e);
    vec_t v;
    v.i = i;
    v.e = e;
    return v;
  endfunction

  function automatic bit mbusy(input int r, input in_t i);
    if (r == 0 || mc[r] == 0) return 1'b0;
    if (BYP && i.wb_we && int'(i.wb_addr) == r && mc[r] == 1)
      return 1'b0;
    return 1'b1;
  endfunction

  // Expected {ready, busy_rs, busy_rt, pending_any, wb_err}
  function automatic logic [4:0] mexp(input in_t i);
    bit brs, brt, sat, rdy, pend;
    brs = i.rs_use && mbusy(int'(i.rs), i);
    brt = i.rt_use && mbusy(int'(i.rt), i);
    sat = i.we && i.rd != 0 && mc[i.rd] == CMAXI;
    rdy = !i.flush && !brs && !brt && !sat;
    pend = 1'b0;
    foreach (mc[r]) if (mc[r] != 0) pend = 1'b1;
    return {rdy, brs, brt, pend, merr};
  endfunction

  task automatic mclear();
    foreach (mc[r]) mc[r] = 0;
    merr = 1'b0;
  endtask

  task automatic mupdate(input in_t i, input bit rdy);
    bit dec, bad;
    if (i.flush) begin
      foreach (mc[r]) mc[r] = 0;
      return;
    end
    dec = i.wb_we && i.wb_addr != 0 && mc[i.wb_addr] > 0;
    bad = i.wb_we && i.wb_addr != 0 && mc[i.wb_addr] == 0;
    if (i.valid && rdy && i.we && i.rd != 0) mc[i.rd]++;
    if (dec) mc[i.wb_addr]--;
    if (bad) merr = 1'b1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e);
    chk({tag, ".iss_ready"},   sb.iss_ready,   e[4]);
    chk({tag, ".busy_rs"},     sb.busy_rs,     e[3]);
    chk({tag, ".busy_rt"},     sb.busy_rt,     e[2]);
    chk({tag, ".pending_any"}, sb.pending_any, e[1]);
    chk({tag, ".wb_err"},      sb.wb_err,      e[0]);
  endtask

  task automatic drive(input in_t i);
    sb.iss_valid  = i.valid;
    sb.iss_rs     = i.rs;
    sb.iss_rs_use = i.rs_use;
    sb.iss_rt     = i.rt;
    sb.iss_rt_use = i.rt_use;
    sb.iss_we     = i.we;
    sb.iss_rd     = i.rd;
    sb.wb_we      = i.wb_we;
    sb.wb_addr    = i.wb_addr;
    sb.flush      = i.flush;
  endtask

  // One cycle: drive at negedge, check mid-low-phase, clock, update model
  task automatic tcyc(input string tag, input in_t i, input logic [4:0] e);
    logic [4:0] m;
    @(negedge clk);
    drive(i);
    #1;
    chk_out(tag, e);
    m = mexp(i);
    @(posedge clk);
    mupdate(i, m[4]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    mclear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl [$];
  in_t  ri;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mclear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_out("reset", 5'b10000);

    // Basic RAW on r8
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0), 5'b10000));
    tbl.push_back(mv(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0), 5'b01010));
    tbl.push_back(mv(mk(1, 8, 1, 0, 0, 0, 0, 1, 8, 0),
                     BYP ? 5'b10010 : 5'b01010));
    tbl.push_back(mv(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0), 5'b10000));
    // Saturation on r3
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b10000));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b10010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b10010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b00010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 1, 3, 0), 5'b00010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 1, 3, 0), 5'b10010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b10010));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0), 5'b00010));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0), 5'b10010));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0), 5'b10010));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0), 5'b10010));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b10000));
    // Register 0 is never tracked
    tbl.push_back(mv(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0), 5'b10000));
    tbl.push_back(mv(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0), 5'b10000));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 5'b10000));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b10000));
    // Spurious writeback and sticky error
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 5'b10000));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b10001));
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0), 5'b10001));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0), 5'b10011));
    tbl.push_back(mv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b10001));
    // RAW through the second source port
    tbl.push_back(mv(mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0), 5'b10001));
    tbl.push_back(mv(mk(1, 12, 0, 12, 1, 0, 0, 0, 0, 0), 5'b00111));
    tbl.push_back(mv(mk(1, 12, 0, 12, 1, 0, 0, 1, 12, 0),
                     BYP ? 5'b10011 : 5'b00111));
    tbl.push_back(mv(mk(1, 12, 0, 12, 1, 0, 0, 0, 0, 0), 5'b10001));

    for (int k = 0; k < tbl.size(); k++)
      tcyc($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Flush overrides same-cycle issue and writeback
    do_reset();
    tcyc("fl_a", mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0), 5'b10000);
    tcyc("fl_b", mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0), 5'b10010);
    tcyc("fl_c", mk(1, 0, 0, 0, 0, 1, 10, 1, 20, 1), 5'b00010);
    tcyc("fl_d", mk(1, 10, 1, 4, 1, 0, 0, 0, 0, 0), 5'b10000);
    tcyc("fl_e", mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0), 5'b10000);

    // Asynchronous reset clears outputs without a clock edge
    tcyc("ar_a", mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0), 5'b10000);
    tcyc("ar_b", mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0), 5'b10001);
    @(negedge clk);
    drive(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk_out("ar_pre", 5'b01011);
    #1;
    reset = 1'b0;
    #1;
    chk_out("ar_post", 5'b10000);
    mclear();
    @(posedge clk);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      ri.valid   = ($urandom_range(0, 9) < 7);
      ri.rs      = 5'($urandom_range(0, 7));
      ri.rs_use  = 1'($urandom_range(0, 1));
      ri.rt      = 5'($urandom_range(0, 7));
      ri.rt_use  = 1'($urandom_range(0, 1));
      ri.we      = ($urandom_range(0, 9) < 6);
      ri.rd      = 5'($urandom_range(0, 7));
      ri.wb_we   = ($urandom_range(0, 9) < 4);
      ri.wb_addr = 5'($urandom_range(0, 7));
      ri.flush   = ($urandom_range(0, 39) == 0);
      if (n == 300) do_reset();
      tcyc($sformatf("rnd%0d", n), ri, mexp(ri));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
